// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the FIFO drain controller.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/drain_out_reg.sv
// drain_out_reg: single-entry valid/ready holding register for drained beats.
// Optional m_last sideband is present when DRAIN_TLAST_EN is defined.
module drain_out_reg
  import fifo_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            accept,
  input  logic [BITS-1:0] d_data,
`ifdef DRAIN_TLAST_EN
  input  logic            d_last,
  output logic            m_last,
`endif
  output logic            m_valid,
  output logic [BITS-1:0] m_data
);

  // Load a new beat, or empty the register once the held beat is taken.
  // A stalled beat is never overwritten because load requires the slot to free up.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
`ifdef DRAIN_TLAST_EN
      m_last  <= 1'b0;
`endif
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= d_data;
`ifdef DRAIN_TLAST_EN
      m_last  <= d_last;
`endif
    end else if (accept) begin
      m_valid <= 1'b0;
`ifdef DRAIN_TLAST_EN
      m_last  <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller that unloads DEPTH entries of the
// shift-register delay FIFO, oldest first, onto a valid/ready stream.
// Optional m_last output is enabled by defining DRAIN_TLAST_EN.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for start; remaining held at 0
//   DRAIN | shifting entries into the output register
//   FLUSH | all entries shifted out, waiting for last beat accept
//   DONE  | one-cycle completion pulse, then back to IDLE
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            fifo_en,
  output logic [BITS-1:0] fifo_d,
  input  logic [BITS-1:0] fifo_q,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [BITS-1:0] m_data
`ifdef DRAIN_TLAST_EN
  ,
  output logic            m_last
`endif
);

  localparam int CW = cnt_width(DEPTH);

  drain_state_t  state;
  logic [CW-1:0] remaining;
  logic          load;
  logic          accept;

  assign accept = m_valid && m_ready;
  // Reset gates the shift immediately so an aborted drain never advances the FIFO.
  assign load    = !rst && (state == DRAIN) && (remaining != '0) && (!m_valid || m_ready);
  assign fifo_en = load;
  assign fifo_d  = '0;

  // Sequencer: entry counter, state transitions and registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= CW'(DEPTH);
            state     <= DRAIN;
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (load) begin
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (accept) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  drain_out_reg #(.BITS(BITS)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .accept  (accept),
    .d_data  (fifo_q),
`ifdef DRAIN_TLAST_EN
    .d_last  (remaining == CW'(1)),
    .m_last  (m_last),
`endif
    .m_valid (m_valid),
    .m_data  (m_data)
  );

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: self-checking bench for fifo_drain (DEPTH=8 and DEPTH=1),
// with a behavioural shift FIFO and a queue/arithmetic reference model.
`timescale 1ns/1ps
module tb_fifo_drain;
  localparam int BITS = 64;
  localparam int DA   = 8;
  localparam int MAXC = 96;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start_a, busy_a, done_a, en_a, valid_a, ready_a;
  logic [BITS-1:0] fd_a, fq_a, data_a;
  logic            start_b, busy_b, done_b, en_b, valid_b, ready_b;
  logic [BITS-1:0] fd_b, fq_b, data_b;
`ifdef DRAIN_TLAST_EN
  logic            last_a, last_b;
`endif

  fifo_drain #(.DEPTH(DA), .BITS(BITS)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .fifo_en(en_a), .fifo_d(fd_a), .fifo_q(fq_a),
    .m_valid(valid_a), .m_ready(ready_a), .m_data(data_a)
`ifdef DRAIN_TLAST_EN
    , .m_last(last_a)
`endif
  );

  fifo_drain #(.DEPTH(1), .BITS(BITS)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .fifo_en(en_b), .fifo_d(fd_b), .fifo_q(fq_b),
    .m_valid(valid_b), .m_ready(ready_b), .m_data(data_b)
`ifdef DRAIN_TLAST_EN
    , .m_last(last_b)
`endif
  );

  // Behavioural shift FIFOs: index 0 is the oldest entry.
  logic [BITS-1:0] mem_a [DA];
  logic [BITS-1:0] pre_a [DA];
  logic            pre_go_a;
  logic [BITS-1:0] mem_b, pre_b;
  logic            pre_go_b;

  assign fq_a = mem_a[0];
  assign fq_b = mem_b;

  always @(posedge clk) begin
    if (pre_go_a) begin
      for (int i = 0; i < DA; i++) mem_a[i] <= pre_a[i];
    end else if (en_a) begin
      for (int i = 0; i < DA - 1; i++) mem_a[i] <= mem_a[i+1];
      mem_a[DA-1] <= fd_a;
    end
    if (pre_go_b) mem_b <= pre_b;
    else if (en_b) mem_b <= fd_b;
  end

  int n_cmp, n_bad;

  // Observations from run_a
  bit              rdy       [MAXC];
  logic            obs_valid [MAXC];
  logic            obs_en    [MAXC];
  logic            obs_busy  [MAXC];
  logic [BITS-1:0] obs_data  [MAXC];
  logic [BITS-1:0] beats[$];
  int              acc_cyc[$];
  int              last_idx[$];
  int              en_count, done_count, done_at;

  // Reference model state
  logic [BITS-1:0] model_q[$];
  logic [BITS-1:0] exp_beat [DA];
  int              exp_acc  [DA];
  int              exp_done;

  task automatic load_fifo(input bit rnd);
    model_q.delete();
    for (int i = 0; i < DA; i++) begin
      pre_a[i] = rnd ? {$urandom, $urandom} : BITS'(DA - i);
      model_q.push_back(pre_a[i]);
    end
    @(negedge clk); pre_go_a = 1'b1;
    @(negedge clk); pre_go_a = 1'b0;
  endtask

  // Beat k is presented the cycle after beat k-1 is taken (first at cycle 2)
  // and taken on the first ready cycle; done follows the last handshake.
  task automatic model_timing();
    int t;
    t = 2;
    for (int k = 0; k < DA; k++) begin
      while (t < MAXC - 1 && !rdy[t]) t++;
      exp_acc[k] = t;
      t = t + 1;
    end
    exp_done = exp_acc[DA-1] + 1;
  endtask

  // A drain pops n entries oldest-first; the FIFO refills with zeros.
  task automatic model_pop(input int n);
    for (int k = 0; k < n; k++) begin
      if (k < DA) exp_beat[k] = model_q[0];
      void'(model_q.pop_front());
      model_q.push_back('0);
    end
  endtask

  task automatic run_a(input int restart_at, input int rst_at, input int ncyc);
    beats.delete(); acc_cyc.delete(); last_idx.delete();
    en_count = 0; done_count = 0; done_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start_a = (c == 0) || (c == restart_at);
      rst     = (c == rst_at);
      ready_a = rdy[c];
      #1;
      obs_valid[c] = valid_a;
      obs_data[c]  = data_a;
      obs_en[c]    = en_a;
      obs_busy[c]  = busy_a;
      if (valid_a && ready_a) begin
        beats.push_back(data_a);
        acc_cyc.push_back(c);
`ifdef DRAIN_TLAST_EN
        if (last_a) last_idx.push_back(beats.size() - 1);
`endif
      end
      if (en_a) en_count++;
      if (done_a) begin
        done_count++;
        if (done_at < 0) done_at = c;
      end
    end
    @(negedge clk);
    start_a = 1'b0; rst = 1'b0; ready_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    n_cmp++; if (data_a !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data_a); end
    n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done: got %b%b want 00", busy_a, done_a); end
    n_cmp++; if (en_a !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_en: got %b want 0", en_a); end
    n_cmp++; if (fd_a !== '0) begin n_bad++; $display("FAIL reset_fifo_d: got %h want 0", fd_a); end
    n_cmp++; if (valid_b !== 1'b0 || busy_b !== 1'b0 || en_b !== 1'b0) begin n_bad++; $display("FAIL reset_dut_b: got v%b b%b e%b want 000", valid_b, busy_b, en_b); end
`ifdef DRAIN_TLAST_EN
    n_cmp++; if (last_a !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", last_a); end
`endif
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_rate();
    int viol;
    bit e;
    load_fifo(1'b0);
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
    model_timing();
    model_pop(DA);
    run_a(-1, -1, 14);
    n_cmp++; if (beats.size() != DA) begin n_bad++; $display("FAIL full_beat_count: got %0d want %0d", beats.size(), DA); end
    for (int k = 0; k < beats.size() && k < DA; k++) begin
      n_cmp++; if (beats[k] !== exp_beat[k]) begin n_bad++; $display("FAIL full_beat_%0d: got %h want %h", k, beats[k], exp_beat[k]); end
      n_cmp++; if (acc_cyc[k] != exp_acc[k]) begin n_bad++; $display("FAIL full_beat_cycle_%0d: got %0d want %0d", k, acc_cyc[k], exp_acc[k]); end
    end
    n_cmp++; if (done_count != 1 || done_at != exp_done) begin n_bad++; $display("FAIL full_done: got %0d pulses at %0d want 1 at %0d", done_count, done_at, exp_done); end
    n_cmp++; if (en_count != DA) begin n_bad++; $display("FAIL full_fifo_en_count: got %0d want %0d", en_count, DA); end
    viol = 0;
    for (int c = 0; c < 14; c++) begin
      e = (c == 1);
      for (int k = 0; k < DA - 1; k++) if (exp_acc[k] == c) e = 1'b1;
      if (obs_en[c] !== e) viol++;
      if (obs_busy[c] !== (c >= 1 && c <= exp_done)) viol++;
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL full_cycle_rules: got %0d violations want 0", viol); end
    viol = 0;
    for (int i = 0; i < DA; i++) if (mem_a[i] !== model_q[i]) viol++;
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL full_fifo_empty: got %0d nonzero entries want 0", viol); end
`ifdef DRAIN_TLAST_EN
    n_cmp++; if (last_idx.size() != 1 || last_idx[0] != DA - 1) begin n_bad++; $display("FAIL full_last: got %0d marks want 1 at beat %0d", last_idx.size(), DA - 1); end
`endif
  endtask

  // Iteration 0 uses ready toggling 1,0,1,0 from cycle 2; later ones are random.
  task automatic test_backpressure();
    int viol;
    bit e;
    for (int it = 0; it < 4; it++) begin
      load_fifo(it != 0);
      for (int c = 0; c < MAXC; c++) begin
        if (it == 0) rdy[c] = (c < 2) ? 1'b1 : (((c - 2) % 2) == 0);
        else rdy[c] = (c >= 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      model_timing();
      model_pop(DA);
      run_a(-1, -1, MAXC);
      n_cmp++; if (beats.size() != DA) begin n_bad++; $display("FAIL bp%0d_beat_count: got %0d want %0d", it, beats.size(), DA); end
      viol = 0;
      for (int k = 0; k < beats.size() && k < DA; k++) begin
        if (beats[k] !== exp_beat[k]) viol++;
        if (acc_cyc[k] != exp_acc[k]) viol++;
      end
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL bp%0d_beats: got %0d wrong data/cycle want 0", it, viol); end
      n_cmp++; if (done_count != 1 || done_at != exp_done) begin n_bad++; $display("FAIL bp%0d_done: got %0d pulses at %0d want 1 at %0d", it, done_count, done_at, exp_done); end
      n_cmp++; if (en_count != DA) begin n_bad++; $display("FAIL bp%0d_fifo_en_count: got %0d want %0d", it, en_count, DA); end
      viol = 0;
      for (int c = 0; c < MAXC; c++) begin
        e = (c == 1);
        for (int k = 0; k < DA - 1; k++) if (exp_acc[k] == c) e = 1'b1;
        if (obs_en[c] !== e) viol++;
        if (obs_busy[c] !== (c >= 1 && c <= exp_done)) viol++;
        if (c > 0 && obs_valid[c-1] === 1'b1 && !rdy[c-1] &&
            (obs_valid[c] !== 1'b1 || obs_data[c] !== obs_data[c-1])) viol++;
      end
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL bp%0d_cycle_rules: got %0d violations want 0", it, viol); end
      viol = 0;
      for (int i = 0; i < DA; i++) if (mem_a[i] !== model_q[i]) viol++;
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL bp%0d_fifo_empty: got %0d nonzero entries want 0", it, viol); end
    end
  endtask

  task automatic test_start_while_busy();
    load_fifo(1'b0);
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
    model_timing();
    model_pop(DA);
    run_a(4, -1, 20);
    n_cmp++; if (beats.size() != DA) begin n_bad++; $display("FAIL restart_beat_count: got %0d want %0d", beats.size(), DA); end
    n_cmp++; if (done_count != 1 || done_at != exp_done) begin n_bad++; $display("FAIL restart_done: got %0d pulses at %0d want 1 at %0d", done_count, done_at, exp_done); end
    n_cmp++; if (en_count != DA) begin n_bad++; $display("FAIL restart_fifo_en_count: got %0d want %0d", en_count, DA); end
    n_cmp++; if (beats.size() > 0 && beats[beats.size()-1] !== exp_beat[DA-1]) begin n_bad++; $display("FAIL restart_last_beat: got %h want %h", beats[beats.size()-1], exp_beat[DA-1]); end
  endtask

  task automatic test_reset_mid_drain();
    int viol;
    load_fifo(1'b0);
    for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
    run_a(-1, 5, 14);
    // At full rate the FIFO shifts in cycles 1..4 before reset lands in cycle 5.
    model_pop(4);
    viol = 0;
    for (int c = 6; c < 14; c++) if (obs_valid[c] !== 1'b0 || obs_busy[c] !== 1'b0 || obs_en[c] !== 1'b0) viol++;
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles after reset want 0", viol); end
    n_cmp++; if (done_count != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_count); end
    n_cmp++; if (en_count != 4) begin n_bad++; $display("FAIL abort_fifo_en_count: got %0d want 4", en_count); end
    model_timing();
    model_pop(DA);
    run_a(-1, -1, 14);
    n_cmp++; if (beats.size() != DA) begin n_bad++; $display("FAIL abort_redrain_count: got %0d want %0d", beats.size(), DA); end
    viol = 0;
    for (int k = 0; k < beats.size() && k < DA; k++) if (beats[k] !== exp_beat[k]) viol++;
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL abort_redrain_data: got %0d wrong beats want 0", viol); end
    n_cmp++; if (done_count != 1 || done_at != exp_done) begin n_bad++; $display("FAIL abort_redrain_done: got %0d pulses at %0d want 1 at %0d", done_count, done_at, exp_done); end
  endtask

  task automatic test_depth1();
    int vcnt, vat, dcnt, dat, ecnt, eat, bviol, lcnt;
    logic [BITS-1:0] vdata;
    vcnt = 0; vat = -1; dcnt = 0; dat = -1; ecnt = 0; eat = -1; bviol = 0; lcnt = 0; vdata = '0;
    pre_b = 64'hA5;
    @(negedge clk); pre_go_b = 1'b1;
    @(negedge clk); pre_go_b = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start_b = (c == 0);
      ready_b = 1'b1;
      #1;
      if (valid_b) begin vcnt++; vat = c; vdata = data_b; end
`ifdef DRAIN_TLAST_EN
      if (valid_b && last_b) lcnt++;
`endif
      if (done_b) begin dcnt++; dat = c; end
      if (en_b) begin ecnt++; eat = c; end
      if (busy_b !== (c >= 1 && c <= 3)) bviol++;
    end
    @(negedge clk); start_b = 1'b0; ready_b = 1'b0;
    n_cmp++; if (vcnt != 1 || vat != 2) begin n_bad++; $display("FAIL d1_beat_cycle: got %0d beats at %0d want 1 at 2", vcnt, vat); end
    n_cmp++; if (vdata !== 64'hA5) begin n_bad++; $display("FAIL d1_beat_data: got %h want a5", vdata); end
    n_cmp++; if (dcnt != 1 || dat != 3) begin n_bad++; $display("FAIL d1_done: got %0d pulses at %0d want 1 at 3", dcnt, dat); end
    n_cmp++; if (ecnt != 1 || eat != 1) begin n_bad++; $display("FAIL d1_fifo_en: got %0d at %0d want 1 at 1", ecnt, eat); end
    n_cmp++; if (bviol != 0) begin n_bad++; $display("FAIL d1_busy: got %0d bad cycles want 0", bviol); end
    n_cmp++; if (mem_b !== '0) begin n_bad++; $display("FAIL d1_fifo_empty: got %h want 0", mem_b); end
`ifdef DRAIN_TLAST_EN
    n_cmp++; if (lcnt != 1) begin n_bad++; $display("FAIL d1_last: got %0d want 1", lcnt); end
`endif
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    start_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; ready_b = 1'b0;
    pre_go_a = 1'b0; pre_go_b = 1'b0; pre_b = '0;
    for (int i = 0; i < DA; i++) pre_a[i] = '0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_drain();
    test_depth1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
